// File: rtl/radix3_bfly_stage.sv
// Streaming radix-3 butterfly: full 3-point DFT of (a, b, c) per cycle,
// three register stages under a single global stall, per-sample fwd/inv.
module radix3_bfly_stage #(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 15,
    parameter int unsigned COEF = 28378
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_img,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_img,
    input  logic signed [DW-1:0] c_re,
    input  logic signed [DW-1:0] c_img,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW+1:0] x0_re,
    output logic signed [DW+1:0] x0_img,
    output logic signed [DW+1:0] x1_re,
    output logic signed [DW+1:0] x1_img,
    output logic signed [DW+1:0] x2_re,
    output logic signed [DW+1:0] x2_img
);

    localparam int unsigned W1 = DW + 1;
    localparam int unsigned W2 = DW + 2;
    localparam int unsigned WP = DW + CW + 2;

    localparam logic signed [CW:0]   COEF_S = (CW+1)'(COEF);
    localparam logic signed [WP-1:0] RND    = WP'(1) << (CW - 1);

    logic adv;

    logic                 s1_valid, s1_inv;
    logic signed [DW-1:0] s1_a_re, s1_a_im;
    logic signed [W1-1:0] s1_t1_re, s1_t1_im, s1_t2_re, s1_t2_im;

    logic                 s2_valid, s2_inv;
    logic signed [W2-1:0] s2_x0_re, s2_x0_im, s2_m_re, s2_m_im;
    logic signed [WP-1:0] s2_p_re, s2_p_im;

    logic signed [W2-1:0] q_re, q_im;
    logic signed [W2-1:0] f1_re, f1_im, f2_re, f2_im;

    // Global stall: everything freezes while an output is offered but not taken.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // S1: b +/- c, carry a and the direction flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_inv   <= 1'b0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_t1_re <= '0;
            s1_t1_im <= '0;
            s1_t2_re <= '0;
            s1_t2_im <= '0;
        end else if (adv) begin
            s1_valid <= in_valid && in_ready;
            s1_inv   <= in_inv;
            s1_a_re  <= a_re;
            s1_a_im  <= a_img;
            s1_t1_re <= W1'(b_re) + W1'(c_re);
            s1_t1_im <= W1'(b_img) + W1'(c_img);
            s1_t2_re <= W1'(b_re) - W1'(c_re);
            s1_t2_im <= W1'(b_img) - W1'(c_img);
        end
    end

    // S2: DC term, midpoint a - t1/2 (floor) and full-precision twiddle products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_inv   <= 1'b0;
            s2_x0_re <= '0;
            s2_x0_im <= '0;
            s2_m_re  <= '0;
            s2_m_im  <= '0;
            s2_p_re  <= '0;
            s2_p_im  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_inv   <= s1_inv;
            s2_x0_re <= W2'(s1_a_re) + W2'(s1_t1_re);
            s2_x0_im <= W2'(s1_a_im) + W2'(s1_t1_im);
            s2_m_re  <= W2'(s1_a_re) - W2'(s1_t1_re >>> 1);
            s2_m_im  <= W2'(s1_a_im) - W2'(s1_t1_im >>> 1);
            s2_p_re  <= WP'(COEF_S) * WP'(s1_t2_re);
            s2_p_im  <= WP'(COEF_S) * WP'(s1_t2_im);
        end
    end

    // Round-half-up rescale of the products, then the forward-direction pair.
    always_comb begin
        q_re  = W2'((s2_p_re + RND) >>> CW);
        q_im  = W2'((s2_p_im + RND) >>> CW);
        f1_re = s2_m_re + q_im;
        f1_im = s2_m_im - q_re;
        f2_re = s2_m_re - q_im;
        f2_im = s2_m_im + q_re;
    end

    // S3: output registers; inverse transform just swaps X1 and X2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x0_re     <= '0;
            x0_img    <= '0;
            x1_re     <= '0;
            x1_img    <= '0;
            x2_re     <= '0;
            x2_img    <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            x0_re     <= s2_x0_re;
            x0_img    <= s2_x0_im;
            x1_re     <= s2_inv ? f2_re : f1_re;
            x1_img    <= s2_inv ? f2_im : f1_im;
            x2_re     <= s2_inv ? f1_re : f2_re;
            x2_img    <= s2_inv ? f1_im : f2_im;
        end
    end

endmodule
